// File: rtl/leaf_out_rr_arbiter_if.sv
// Bundle of the requester-side and leaf_interface-side handshake signals of
// leaf_out_rr_arbiter. master = arbiter side, slave = producers plus leaf_interface.
interface leaf_out_rr_arbiter_if #(
    parameter int unsigned PAYLOAD_BITS = 32,
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned REQ_BITS     = 1
);
    logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req;
    logic [NUM_REQ-1:0]              vld_req;
    logic [NUM_REQ-1:0]              ack_req;
    logic [PAYLOAD_BITS-1:0]         dout;
    logic                            vld_out;
    logic                            ack_out;
    logic [REQ_BITS-1:0]             grant_id;
    logic                            busy;

    modport master (
        input  din_req, vld_req, ack_out,
        output ack_req, dout, vld_out, grant_id, busy
    );

    modport slave (
        output din_req, vld_req, ack_out,
        input  ack_req, dout, vld_out, grant_id, busy
    );
endinterface

// File: rtl/leaf_out_rr_arbiter.sv
// Burst-granular round-robin arbiter sharing one leaf_interface output port
// among NUM_REQ producers, with a single registered output stage.
module leaf_out_rr_arbiter #(
    parameter int unsigned PAYLOAD_BITS = 32,
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned REQ_BITS     = 1,
    parameter int unsigned BURST_LEN    = 16,
    parameter int unsigned BURST_BITS   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    leaf_out_rr_arbiter_if.master  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state_q;
    logic [REQ_BITS-1:0]     rr_ptr_q;
    logic [REQ_BITS-1:0]     grant_id_q;
    logic [BURST_BITS-1:0]   burst_cnt_q;
    logic [BURST_BITS-1:0]   burst_cnt_d;
    logic                    vld_out_q;
    logic [PAYLOAD_BITS-1:0] dout_q;

    logic                    space;
    logic                    accept;
    logic                    found;
    logic [REQ_BITS-1:0]     pick;
    logic [REQ_BITS-1:0]     cand;
    logic [31:0]             cand_w;
    logic [REQ_BITS-1:0]     next_ptr;
    logic [PAYLOAD_BITS-1:0] din_sel;
    logic [NUM_REQ-1:0]      ack_req_d;

    assign space       = !vld_out_q || bus.ack_out;
    assign accept      = (state_q == GRANT) && bus.vld_req[grant_id_q] && space;
    assign burst_cnt_d = burst_cnt_q + 1'b1;
    assign next_ptr    = (grant_id_q == REQ_BITS'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        cand   = '0;
        cand_w = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_w = 32'(rr_ptr_q) + k;
            if (cand_w >= NUM_REQ) cand_w = cand_w - NUM_REQ;
            cand = REQ_BITS'(cand_w);
            if (!found && bus.vld_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        din_sel   = '0;
        ack_req_d = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == REQ_BITS'(i)) begin
                din_sel      = bus.din_req[i*PAYLOAD_BITS +: PAYLOAD_BITS];
                ack_req_d[i] = (state_q == GRANT) && space;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
            vld_out_q   <= 1'b0;
            dout_q      <= '0;
        end else begin
            if (accept) begin
                dout_q    <= din_sel;
                vld_out_q <= 1'b1;
            end else if (space) begin
                vld_out_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q     <= GRANT;
                        grant_id_q  <= pick;
                        burst_cnt_q <= '0;
                    end
                end
                GRANT: begin
                    if (!bus.vld_req[grant_id_q]) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= next_ptr;
                    end else if (space) begin
                        burst_cnt_q <= burst_cnt_d;
                        if (burst_cnt_d == BURST_BITS'(BURST_LEN)) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= next_ptr;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack_req  = ack_req_d;
    assign bus.dout     = dout_q;
    assign bus.vld_out  = vld_out_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = (state_q == GRANT) || vld_out_q;
endmodule

// File: tb/tb_leaf_out_rr_arbiter.sv
// Directed bench for leaf_out_rr_arbiter (3 requesters, 4-word bursts) with a
// queue scoreboard of expected output words and per-cycle state checks.
module tb_leaf_out_rr_arbiter;
    localparam int unsigned PB = 32;
    localparam int unsigned NR = 3;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [PB-1:0] exp_q[$];
    logic [PB-1:0] src0[$];
    logic [PB-1:0] src1[$];
    logic [PB-1:0] src2[$];
    logic [NR-1:0] ack_seen;

    leaf_out_rr_arbiter_if #(.PAYLOAD_BITS(PB), .NUM_REQ(NR), .REQ_BITS(2)) bus ();

    leaf_out_rr_arbiter #(
        .PAYLOAD_BITS(PB),
        .NUM_REQ(NR),
        .REQ_BITS(2),
        .BURST_LEN(4),
        .BURST_BITS(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PB-1:0] mk(input int r, input int n);
        logic [7:0] tag;
        tag = 8'hA0 + 8'(r);
        return {tag, 24'(n)};
    endfunction

    task automatic chk(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_src(input int r, input int first, input int n);
        for (int k = 0; k < n; k++) begin
            case (r)
                0:       src0.push_back(mk(r, first + k));
                1:       src1.push_back(mk(r, first + k));
                default: src2.push_back(mk(r, first + k));
            endcase
        end
    endtask

    task automatic expect_words(input int r, input int first, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(mk(r, first + k));
    endtask

    task automatic drive();
        logic [NR*PB-1:0] d;
        logic [NR-1:0]    v;
        d = '0;
        v = '0;
        if (src0.size() > 0) begin v[0] = 1'b1; d[0*PB +: PB] = src0[0]; end
        if (src1.size() > 0) begin v[1] = 1'b1; d[1*PB +: PB] = src1[0]; end
        if (src2.size() > 0) begin v[2] = 1'b1; d[2*PB +: PB] = src2[0]; end
        bus.din_req = d;
        bus.vld_req = v;
    endtask

    // One clock: drive producers, observe handshakes mid-cycle, retire accepted words after the edge.
    task automatic cycle();
        logic [NR-1:0] acc;
        logic [PB-1:0] e;
        @(negedge clk);
        drive();
        #1;
        acc      = reset ? '0 : (bus.vld_req & bus.ack_req);
        ack_seen = bus.ack_req;
        if (!reset && bus.vld_out && bus.ack_out) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL sb_extra observed=%0h expected=none", bus.dout);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_data", bus.dout, e);
            end
        end
        @(posedge clk);
        #1;
        if (acc[0] && src0.size() > 0) void'(src0.pop_front());
        if (acc[1] && src1.size() > 0) void'(src1.pop_front());
        if (acc[2] && src2.size() > 0) void'(src2.pop_front());
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        bus.ack_out = 1'b0;
        bus.din_req = '0;
        bus.vld_req = '0;
        ack_seen    = '0;

        // Reset state
        cycle();
        cycle();
        chk("rst_vld_out", 32'(bus.vld_out), 32'd0);
        chk("rst_dout", bus.dout, 32'd0);
        chk("rst_ack_req", 32'(bus.ack_req), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_grant", 32'(bus.grant_id), 32'd0);
        reset = 1'b0;

        // 1: req0 sends three words back to back
        bus.ack_out = 1'b1;
        load_src(0, 1, 3);
        expect_words(0, 1, 3);
        cycle();
        chk("t1_grant_c1", 32'(bus.grant_id), 32'd0);
        chk("t1_busy_c1", 32'(bus.busy), 32'd1);
        chk("t1_vld_c1", 32'(bus.vld_out), 32'd0);
        for (int k = 2; k <= 4; k++) begin
            cycle();
            chk("t1_vld_burst", 32'(bus.vld_out), 32'd1);
            chk("t1_dout", bus.dout, mk(0, k - 1));
        end
        cycle();
        chk("t1_vld_c5", 32'(bus.vld_out), 32'd0);
        cycle();
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // 2: two saturated requesters rotate every 4 words with a 1-cycle bubble
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        load_src(0, 'h10, 8);
        load_src(1, 'h10, 8);
        expect_words(0, 'h10, 4);
        expect_words(1, 'h10, 4);
        expect_words(0, 'h14, 4);
        expect_words(1, 'h14, 4);
        for (int k = 1; k <= 21; k++) begin
            cycle();
            if (k >= 2) chk("t2_vld_pattern", 32'(bus.vld_out), ((k - 2) % 5 != 4) ? 32'd1 : 32'd0);
            if (k <= 20) chk("t2_grant", 32'(bus.grant_id), 32'(((k - 1) / 5) % 2));
        end
        cycle();
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // 3: ack_out held low for 5 cycles mid-burst
        load_src(0, 'h20, 6);
        expect_words(0, 'h20, 6);
        cycle();
        chk("t3_grant", 32'(bus.grant_id), 32'd0);
        cycle();
        cycle();
        bus.ack_out = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t3_hold_vld", 32'(bus.vld_out), 32'd1);
            chk("t3_hold_dout", bus.dout, mk(0, 'h21));
            chk("t3_hold_ack_req", 32'(ack_seen), 32'd0);
        end
        bus.ack_out = 1'b1;
        for (int k = 0; k < 10; k++) cycle();
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // 4: req0 drops valid after two words while req1 waits
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        load_src(0, 'h30, 2);
        load_src(1, 'h30, 3);
        expect_words(0, 'h30, 2);
        expect_words(1, 'h30, 3);
        cycle();
        chk("t4_grant0", 32'(bus.grant_id), 32'd0);
        cycle();
        cycle();
        cycle();
        chk("t4_idle_busy", 32'(bus.busy), 32'd0);
        chk("t4_idle_grant", 32'(bus.grant_id), 32'd0);
        cycle();
        chk("t4_grant1", 32'(bus.grant_id), 32'd1);
        chk("t4_busy1", 32'(bus.busy), 32'd1);
        for (int k = 0; k < 6; k++) cycle();
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5: req2 bursts, pointer wraps to 0, then req0 before req1
        load_src(2, 'h40, 4);
        load_src(0, 'h40, 2);
        load_src(1, 'h40, 2);
        expect_words(2, 'h40, 4);
        expect_words(0, 'h40, 2);
        expect_words(1, 'h40, 2);
        for (int k = 1; k <= 15; k++) begin
            cycle();
            if (k == 1)  chk("t5_grant2", 32'(bus.grant_id), 32'd2);
            if (k == 6)  chk("t5_grant0", 32'(bus.grant_id), 32'd0);
            if (k == 10) chk("t5_grant1", 32'(bus.grant_id), 32'd1);
        end
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // 6: reset mid-burst with a held output word
        load_src(0, 'h50, 3);
        cycle();
        cycle();
        chk("t6_vld_before", 32'(bus.vld_out), 32'd1);
        bus.ack_out = 1'b0;
        reset       = 1'b1;
        cycle();
        chk("t6_vld_out", 32'(bus.vld_out), 32'd0);
        chk("t6_dout", bus.dout, 32'd0);
        chk("t6_ack_req", 32'(bus.ack_req), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_grant", 32'(bus.grant_id), 32'd0);
        reset = 1'b0;
        src0.delete();
        bus.ack_out = 1'b1;
        cycle();
        cycle();
        chk("t6_vld_after", 32'(bus.vld_out), 32'd0);
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
